ternary_dense_acc: RTL and testbench
====================================

// Module: ternary_dense_acc
// PURPOSE
//  Consumer side of the ternary-weight ROM interface for dense layer 1.
//  - Drives the ROM address counter d1_cntr and reads the 2-bit weight dw_1.
//  - Multiplies each streamed activation by its ternary weight and accumulates over D1_CYC beats.
//  - Emits one signed dot-product result per frame on a valid/ready output.
// PARAMETERS
//  D1_BW_A      8    activation width, signed two's complement
//  D1_BW_W      2    weight code width (fixed at 2)
//  LOG2_D1_CYC  9    counter width
//  D1_CYC       512  beats per frame; must equal 2**LOG2_D1_CYC
//  ACC_W        D1_BW_A+LOG2_D1_CYC+1 (=18)  localparam; accumulator/result width, signed
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  in_data    in   D1_BW_A      activation sample, signed
//  in_valid   in   1            in_data valid
//  in_ready   out  1            block accepts in_data this cycle
//  d1_cntr    out  LOG2_D1_CYC  weight ROM address, registered
//  dw_1       in   D1_BW_W      weight code from ROM, combinational from d1_cntr
//  out_data   out  ACC_W        frame result, signed
//  out_valid  out  1            out_data valid
//  out_ready  in   1            downstream accepts out_data
// BEHAVIOUR
//  - Reset values: state=RUN, d1_cntr=0, acc=0, out_data=0, out_valid=0, in_ready=1.
//  - Weight decode:
//    2'b01 -> +1; 2'b11 -> -1; 2'b00 -> 0.
//    2'b10 is reserved; it decodes to 0.
//  - Term = +in_data, -in_data or 0, sign-extended to ACC_W. Negating -2**(D1_BW_A-1) is exact in ACC_W.
//  - States:
//    RUN: in_ready=1.
//      Beat (in_valid&in_ready) with d1_cntr<D1_CYC-1: acc<=acc+term; d1_cntr<=d1_cntr+1.
//      Beat with d1_cntr==D1_CYC-1: out_data<=acc+term; out_valid<=1; acc<=0; d1_cntr<=0 (wrap); go OUT.
//      No beat: all state holds.
//    OUT: in_ready=0; out_data and out_valid held stable.
//      out_ready=1: out_valid<=0; go RUN.
//  - Latency: out_valid rises on the cycle after the last accepted beat. Frame-to-frame bubble = 1 cycle minimum.
//  - dw_1 is sampled in the same cycle as the beat, at the current d1_cntr; the ROM path is combinational.
//  - in_valid during OUT: no beat; the producer must hold its data (standard valid/ready).
//  - out_ready asserted with in_valid in OUT: result retires, no beat that cycle, RUN next cycle.
//  - rst_n low mid-frame: immediate clear to reset values; the partial frame is discarded.
//  - No overflow possible: |sum| <= D1_CYC*2**(D1_BW_A-1) = 65536 fits ACC_W=18 signed.
// CONFIGURATION
//  D1_RELU_EN defined: out_data<=(acc+term)<0 ? 0 : acc+term at frame end.
//  D1_RELU_EN undefined: raw signed sum.
//  acc is unaffected in either case.
// STRUCTURE
//  Package ternary_pkg:
//    - W_ZERO=2'b00, W_POS=2'b01, W_NEG=2'b11, W_RSVD=2'b10.
//    - typedef state_t {RUN, OUT}.
//    - function ternary_decode.
//  Sub-module ternary_term: combinational in_data x dw_1 -> ACC_W signed term.
//  Top holds the FSM, counter and accumulator.
// TESTING (bench models the ROM as an array indexed by d1_cntr)
//  1. ROM all W_POS, in_data=1 for 512 beats -> out_data=512, out_valid the cycle after beat 512.
//  2. ROM all W_NEG, in_data=-128 -> out_data=+65536. ROM all W_NEG, in_data=127 -> -65024 (RELU build: 0).
//  3. ROM alternating W_POS/W_NEG from addr 0, in_data=5, random in_valid gaps -> out_data=0; d1_cntr=0 afterwards.
//  4. out_ready low for 20 cycles after frame -> out_valid/out_data stable, in_ready=0, no beats consumed.
//  5. ROM all W_RSVD, in_data=100 -> out_data=0.
//  6. rst_n pulse after beat 300 -> d1_cntr=0, acc=0. Next full frame of test 1 -> 512.

Source files
------------

// File: rtl/ternary_dense_acc_pkg.sv
// Shared definitions for the dense-layer-1 ternary accumulator.
// Holds the weight codes, the FSM state type and the weight decoder.
package ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;
  localparam logic [1:0] W_RSVD = 2'b10;

  typedef enum logic {
    RUN = 1'b0,
    OUT = 1'b1
  } state_t;

  // The reserved code decodes to zero, the same as W_ZERO.
  function automatic logic signed [1:0] ternary_decode(input logic [1:0] code);
    logic signed [1:0] w;
    case (code)
      W_POS:   w = 2'sb01;
      W_NEG:   w = 2'sb11;
      default: w = 2'sb00;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ternary_dense_acc_if.sv
// Bundles the activation stream, the weight-ROM port and the result stream.
// The master modport is the accumulator side; the slave is its environment.
interface ternary_dense_acc_if #(
  parameter int D1_BW_A     = 8,
  parameter int D1_BW_W     = 2,
  parameter int LOG2_D1_CYC = 9
) ();
  localparam int ACC_W = D1_BW_A + LOG2_D1_CYC + 1;

  logic signed [D1_BW_A-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [LOG2_D1_CYC-1:0]    d1_cntr;
  logic [D1_BW_W-1:0]        dw_1;
  logic signed [ACC_W-1:0]   out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    input  in_data, in_valid, dw_1, out_ready,
    output in_ready, d1_cntr, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, dw_1, out_ready,
    input  in_ready, d1_cntr, out_data, out_valid
  );
endinterface

// File: rtl/ternary_dense_acc_term.sv
// Combinational product of one signed activation and one ternary weight code,
// sign-extended to the accumulator width.
module ternary_term
  import ternary_pkg::*;
#(
  parameter int D1_BW_A = 8,
  parameter int D1_BW_W = 2,
  parameter int ACC_W   = 18
) (
  input  logic signed [D1_BW_A-1:0] in_data,
  input  logic [D1_BW_W-1:0]        dw,
  output logic signed [ACC_W-1:0]   term
);

  logic signed [ACC_W-1:0] ext;
  logic signed [1:0]       w;

  // Negation happens after widening, so the most negative activation negates exactly.
  assign ext = ACC_W'(in_data);
  assign w   = ternary_decode(dw);

  always_comb begin
    term = '0;
    if (w == 2'sb01) begin
      term = ext;
    end else if (w == 2'sb11) begin
      term = -ext;
    end
  end

endmodule

// File: rtl/ternary_dense_acc.sv
// Streams activations against ROM weights and emits one dot product per frame.
// Optional macro D1_RELU_EN clamps negative frame results to zero.
module ternary_dense_acc
  import ternary_pkg::*;
#(
  parameter int D1_BW_A     = 8,
  parameter int D1_BW_W     = 2,
  parameter int LOG2_D1_CYC = 9,
  parameter int D1_CYC      = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  ternary_dense_acc_if.master bus
);

  localparam int ACC_W = D1_BW_A + LOG2_D1_CYC + 1;
  localparam logic [LOG2_D1_CYC-1:0] LAST_ADDR = LOG2_D1_CYC'(D1_CYC - 1);

  state_t                   state_q, state_d;
  logic [LOG2_D1_CYC-1:0]   cntr_q, cntr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  result;
  logic                     in_ready;
  logic                     beat;

  ternary_term #(
    .D1_BW_A (D1_BW_A),
    .D1_BW_W (D1_BW_W),
    .ACC_W   (ACC_W)
  ) u_term (
    .in_data (bus.in_data),
    .dw      (bus.dw_1),
    .term    (term)
  );

  assign in_ready = (state_q == RUN);
  assign beat     = bus.in_valid & in_ready;
  assign sum      = acc_q + term;

`ifdef D1_RELU_EN
  assign result = sum[ACC_W-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  always_comb begin
    state_d     = state_q;
    cntr_d      = cntr_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      RUN: begin
        if (beat) begin
          if (cntr_q == LAST_ADDR) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cntr_d      = '0;
            state_d     = OUT;
          end else begin
            acc_d  = sum;
            cntr_d = cntr_q + 1'b1;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cntr_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntr_q      <= cntr_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.d1_cntr   = cntr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_ternary_dense_acc.sv
// Self-checking bench for ternary_dense_acc: ROM modelled as an array indexed by d1_cntr,
// expected frame sums computed directly as sum(weight * activation).
module tb_ternary_dense_acc;
  import ternary_pkg::*;

  localparam int N     = 512;
  localparam int LOG2N = 9;
  localparam int ACC_W = 18;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ternary_dense_acc_if #(.D1_BW_A(8), .D1_BW_W(2), .LOG2_D1_CYC(LOG2N)) bus ();

  ternary_dense_acc #(
    .D1_BW_A(8), .D1_BW_W(2), .LOG2_D1_CYC(LOG2N), .D1_CYC(N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [1:0] rom [N];
  int         dat [N];
  int         errors = 0;
  int         checks = 0;

  assign bus.dw_1 = rom[bus.d1_cntr];

  function automatic int wval(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int expect_sum();
    int s = 0;
    for (int k = 0; k < N; k++) s += wval(rom[k]) * dat[k];
`ifdef D1_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Feeds nbeats activations (with random idle gaps), then for a full frame checks the
  // result, holds out_ready low for 'hold' cycles while offering data, and retires it.
  task automatic run_frame(input string name, input int nbeats, input int gap_max, input int hold);
    int                      exp_i;
    int                      g;
    logic signed [ACC_W-1:0] exp_v;
    logic signed [ACC_W-1:0] held;
    exp_i = expect_sum();
    exp_v = ACC_W'(exp_i);
    for (int k = 0; k < nbeats; k++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus.d1_cntr !== LOG2N'(k)) begin
        errors++;
        $display("FAIL %s cntr beat %0d: got %0d want %0d", name, k, bus.d1_cntr, k);
      end
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL %s run_flags beat %0d: in_ready/out_valid got %b want 10", name, k,
                 {bus.in_ready, bus.out_valid});
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(dat[k]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (nbeats < N) return;

    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.d1_cntr !== '0) begin
      errors++;
      $display("FAIL %s end_flags: out_valid=%b in_ready=%b cntr=%0d want 1 0 0", name,
               bus.out_valid, bus.in_ready, bus.d1_cntr);
    end
    checks++;
    if (bus.out_data !== exp_v) begin
      errors++;
      $display("FAIL %s out_data: got %0d want %0d", name, bus.out_data, exp_v);
    end
    $display("frame %s: out_data=%0d expected=%0d hold=%0d", name, bus.out_data, exp_v, hold);

    held = bus.out_data;
    repeat (hold) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0 ||
          bus.d1_cntr !== '0) begin
        errors++;
        $display("FAIL %s hold: out_valid=%b out_data=%0d in_ready=%b cntr=%0d want 1 %0d 0 0",
                 name, bus.out_valid, bus.out_data, bus.in_ready, bus.d1_cntr, held);
      end
    end
    // Retire with in_valid still high: no beat may be taken in that cycle.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.d1_cntr !== '0) begin
      errors++;
      $display("FAIL %s retire: out_valid=%b in_ready=%b cntr=%0d want 0 1 0", name,
               bus.out_valid, bus.in_ready, bus.d1_cntr);
    end
  endtask

  task automatic fill(input logic [1:0] w, input int d);
    for (int k = 0; k < N; k++) begin
      rom[k] = w;
      dat[k] = d;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    fill(W_ZERO, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.d1_cntr !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset: cntr=%0d out_valid=%b in_ready=%b out_data=%0d want 0 0 1 0",
               bus.d1_cntr, bus.out_valid, bus.in_ready, bus.out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_pos();
    fill(W_POS, 1);
    run_frame("all_pos", N, 0, 0);
  endtask

  task automatic test_all_neg();
    fill(W_NEG, -128);
    run_frame("neg_min", N, 0, 0);
    fill(W_NEG, 127);
    run_frame("neg_max", N, 1, 0);
  endtask

  task automatic test_alternating();
    for (int k = 0; k < N; k++) begin
      rom[k] = (k % 2 == 0) ? W_POS : W_NEG;
      dat[k] = 5;
    end
    run_frame("alternating", N, 3, 0);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < N; k++) begin
      rom[k] = 2'($urandom_range(0, 3));
      dat[k] = int'($urandom_range(0, 255)) - 128;
    end
    run_frame("backpressure", N, 0, 20);
  endtask

  task automatic test_reserved();
    fill(W_RSVD, 100);
    run_frame("reserved", N, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) begin
        rom[k] = 2'($urandom_range(0, 3));
        dat[k] = int'($urandom_range(0, 255)) - 128;
      end
      run_frame("random", N, 2, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    fill(W_NEG, 77);
    run_frame("partial", 300, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.d1_cntr !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: cntr=%0d out_valid=%b in_ready=%b out_data=%0d want 0 0 1 0",
               bus.d1_cntr, bus.out_valid, bus.in_ready, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fill(W_POS, 1);
    run_frame("after_reset", N, 0, 0);
  endtask

  initial begin
    test_reset();
    test_all_pos();
    test_all_neg();
    test_alternating();
    test_backpressure();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
